mac_lookup_ctrl: RTL and testbench

MAC_LOOKUP_CTRL -- requirements
Module: mac_lookup_ctrl

---
 rtl/mac_lookup_ctrl_pkg.sv | 21 ++
 rtl/mac_lookup_ctrl_if.sv | 42 ++++
 rtl/mac_lookup_ctrl_hash.sv | 11 +
 rtl/mac_lookup_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mac_lookup_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_lookup_ctrl_pkg.sv
// Shared widths, multicast bit position and FSM encoding for the MAC lookup controller.
package mac_lookup_ctrl_pkg;

  localparam int MAC_W     = 48;
  localparam int HASH_W    = 10;
  localparam int PORT_W    = 16;
  localparam int INPORT_W  = 4;
  localparam int MCAST_BIT = 40;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LEARN  = 2'd1,
    ST_LOOKUP = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  function automatic logic [PORT_W-1:0] port_onehot(input logic [INPORT_W-1:0] port);
    return {{(PORT_W-1){1'b0}}, 1'b1} << port;
  endfunction

endpackage

// File: rtl/mac_lookup_ctrl_if.sv
// Header, forwarding, search-engine and aging signals of the MAC lookup controller.
interface mac_lookup_ctrl_if;
  import mac_lookup_ctrl_pkg::*;

  logic                hdr_valid;
  logic                hdr_ready;
  logic [MAC_W-1:0]    hdr_dmac;
  logic [MAC_W-1:0]    hdr_smac;
  logic [INPORT_W-1:0] hdr_inport;

  logic                fwd_valid;
  logic                fwd_ready;
  logic [PORT_W-1:0]   fwd_portmap;
  logic                fwd_flood;

  logic                se_source;
  logic [MAC_W-1:0]    se_mac;
  logic [PORT_W-1:0]   se_portmap;
  logic [HASH_W-1:0]   se_hash;
  logic                se_req;
  logic                se_ack;
  logic                se_nak;
  logic [PORT_W-1:0]   se_result;

  logic                aging_req;
  logic                aging_ack;

  modport master (
    output hdr_valid, hdr_dmac, hdr_smac, hdr_inport, fwd_ready,
           se_ack, se_nak, se_result, aging_ack,
    input  hdr_ready, fwd_valid, fwd_portmap, fwd_flood,
           se_source, se_mac, se_portmap, se_hash, se_req, aging_req
  );

  modport slave (
    input  hdr_valid, hdr_dmac, hdr_smac, hdr_inport, fwd_ready,
           se_ack, se_nak, se_result, aging_ack,
    output hdr_ready, fwd_valid, fwd_portmap, fwd_flood,
           se_source, se_mac, se_portmap, se_hash, se_req, aging_req
  );

endinterface

// File: rtl/mac_lookup_ctrl_hash.sv
// Bucket hash: XOR-fold of a 48-bit MAC into 10 bits (top byte zero-extended).
module mac_hash
  import mac_lookup_ctrl_pkg::*;
(
  input  logic [MAC_W-1:0]  mac,
  output logic [HASH_W-1:0] hash
);

  assign hash = mac[9:0] ^ mac[19:10] ^ mac[29:20] ^ mac[39:30] ^ {2'b00, mac[47:40]};

endmodule

// File: rtl/mac_lookup_ctrl.sv
// Per-frame learn/lookup sequencer in front of a MAC search engine.
// Optional aging-sweep timer is compiled in when MAC_AGING_EN is defined.
module mac_lookup_ctrl
  import mac_lookup_ctrl_pkg::*;
#(
  parameter logic [31:0] AGING_PERIOD = 32'd50_000_000,
  parameter logic [7:0]  SE_TIMEOUT   = 8'd255
) (
  input logic              clk,
  input logic              rstn,
  mac_lookup_ctrl_if.slave bus
);

  state_t              state, state_nxt;
  logic [MAC_W-1:0]    dmac_q;
  logic [INPORT_W-1:0] inport_q;
  logic [HASH_W-1:0]   smac_hash, dmac_hash;
  logic                se_req_q, se_source_q;
  logic [MAC_W-1:0]    se_mac_q;
  logic [PORT_W-1:0]   se_portmap_q;
  logic [HASH_W-1:0]   se_hash_q;
  logic [7:0]          to_cnt;
  logic [1:0]          lat_cnt;
  logic                decided;
  logic [PORT_W-1:0]   fwd_portmap_q;
  logic                fwd_flood_q;
  logic                hdr_ready_c, fwd_valid_c;
  logic                se_resp, se_timeout, se_done, dmac_mcast, lookup_resolved;

  mac_hash u_smac_hash (.mac(bus.hdr_smac), .hash(smac_hash));
  mac_hash u_dmac_hash (.mac(dmac_q),       .hash(dmac_hash));

  assign se_resp         = se_req_q && (bus.se_ack || bus.se_nak);
  assign se_timeout      = se_req_q && !se_resp && (to_cnt == SE_TIMEOUT - 8'd1);
  assign se_done         = se_resp || se_timeout;
  assign dmac_mcast      = dmac_q[MCAST_BIT];
  assign lookup_resolved = decided || dmac_mcast || se_done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // OUT is entered only once the decision exists and three edges have passed since acceptance.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.hdr_valid) state_nxt = bus.hdr_smac[MCAST_BIT] ? ST_LOOKUP : ST_LEARN;
      ST_LEARN:  if (se_done) state_nxt = ST_LOOKUP;
      ST_LOOKUP: if (lookup_resolved && (lat_cnt >= 2'd2)) state_nxt = ST_OUT;
      ST_OUT:    if (bus.fwd_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    hdr_ready_c = 1'b0;
    fwd_valid_c = 1'b0;
    case (state)
      ST_IDLE: hdr_ready_c = rstn;
      ST_OUT:  fwd_valid_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dmac_q        <= '0;
      inport_q      <= '0;
      se_req_q      <= 1'b0;
      se_source_q   <= 1'b0;
      se_mac_q      <= '0;
      se_portmap_q  <= '0;
      se_hash_q     <= '0;
      to_cnt        <= '0;
      lat_cnt       <= '0;
      decided       <= 1'b0;
      fwd_portmap_q <= '0;
      fwd_flood_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          lat_cnt <= '0;
          decided <= 1'b0;
          if (bus.hdr_valid) begin
            dmac_q   <= bus.hdr_dmac;
            inport_q <= bus.hdr_inport;
            if (!bus.hdr_smac[MCAST_BIT]) begin
              se_req_q     <= 1'b1;
              se_source_q  <= 1'b1;
              se_mac_q     <= bus.hdr_smac;
              se_portmap_q <= port_onehot(bus.hdr_inport);
              se_hash_q    <= smac_hash;
              to_cnt       <= '0;
            end
          end
        end
        ST_LEARN: begin
          if (lat_cnt != 2'd3) lat_cnt <= lat_cnt + 2'd1;
          if (se_done)       se_req_q <= 1'b0;
          else if (se_req_q) to_cnt   <= to_cnt + 8'd1;
        end
        ST_LOOKUP: begin
          if (lat_cnt != 2'd3) lat_cnt <= lat_cnt + 2'd1;
          if (!decided) begin
            // Broadcast/multicast destinations never reach the search engine.
            if (dmac_mcast) begin
              decided       <= 1'b1;
              fwd_portmap_q <= ~port_onehot(inport_q);
              fwd_flood_q   <= 1'b1;
            end else if (se_req_q) begin
              if (se_done) begin
                se_req_q <= 1'b0;
                decided  <= 1'b1;
                if (se_req_q && bus.se_ack) begin
                  fwd_portmap_q <= bus.se_result & ~port_onehot(inport_q);
                  fwd_flood_q   <= 1'b0;
                end else begin
                  fwd_portmap_q <= ~port_onehot(inport_q);
                  fwd_flood_q   <= 1'b1;
                end
              end else begin
                to_cnt <= to_cnt + 8'd1;
              end
            end else begin
              se_req_q     <= 1'b1;
              se_source_q  <= 1'b0;
              se_mac_q     <= dmac_q;
              se_portmap_q <= '0;
              se_hash_q    <= dmac_hash;
              to_cnt       <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hdr_ready   = hdr_ready_c;
  assign bus.fwd_valid   = fwd_valid_c;
  assign bus.fwd_portmap = fwd_portmap_q;
  assign bus.fwd_flood   = fwd_flood_q;
  assign bus.se_req      = se_req_q;
  assign bus.se_source   = se_source_q;
  assign bus.se_mac      = se_mac_q;
  assign bus.se_portmap  = se_portmap_q;
  assign bus.se_hash     = se_hash_q;

`ifdef MAC_AGING_EN
  logic [31:0] age_cnt;
  logic        aging_req_q;

  // Timer freezes while a sweep is outstanding and restarts from zero after the ack.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      age_cnt     <= '0;
      aging_req_q <= 1'b0;
    end else if (aging_req_q) begin
      if (bus.aging_ack) aging_req_q <= 1'b0;
    end else if (age_cnt == AGING_PERIOD - 32'd1) begin
      aging_req_q <= 1'b1;
      age_cnt     <= '0;
    end else begin
      age_cnt <= age_cnt + 32'd1;
    end
  end

  assign bus.aging_req = aging_req_q;
`else
  logic unused_aging_ack;
  assign unused_aging_ack = bus.aging_ack;
  assign bus.aging_req    = 1'b0;
`endif

endmodule

// File: tb/tb_mac_lookup_ctrl.sv
// Self-checking bench for mac_lookup_ctrl; acts as header source, search engine and decision sink.
// Define MAC_AGING_EN to also exercise the aging timer with a 100-cycle period.
module tb_mac_lookup_ctrl;

`ifdef MAC_AGING_EN
  localparam logic [31:0] TB_AGING_PERIOD = 32'd100;
`else
  localparam logic [31:0] TB_AGING_PERIOD = 32'd50_000_000;
`endif

  typedef enum logic [1:0] {R_ACK, R_NAK, R_BOTH, R_NONE} resp_t;

  typedef struct {
    logic [47:0] dmac;
    logic [47:0] smac;
    logic [3:0]  inport;
    resp_t       learn_resp;
    resp_t       lk_resp;
    logic [15:0] lk_result;
    int          dly;
    bit          noise;
    logic [15:0] exp_pm;
    logic        exp_fl;
  } vec_t;

  logic clk;
  logic rstn;
  int   tests;
  int   failures;

  mac_lookup_ctrl_if bus();

  mac_lookup_ctrl #(.AGING_PERIOD(TB_AGING_PERIOD), .SE_TIMEOUT(8'd255)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [47:0] dmac, input logic [47:0] smac,
                               input logic [3:0] inport, input logic valid);
    bus.hdr_dmac   = dmac;
    bus.hdr_smac   = smac;
    bus.hdr_inport = inport;
    bus.hdr_valid  = valid;
  endtask

  function automatic logic [9:0] hash_ref(input logic [47:0] m);
    logic [49:0] ext;
    logic [9:0]  h;
    ext = {2'b00, m};
    h   = '0;
    for (int i = 0; i < 5; i++) h ^= ext[i*10 +: 10];
    return h;
  endfunction

  // Forwarding decision straight from the rules: flood unless a unicast lookup was acked.
  function automatic void ref_decision(input vec_t v, output logic [15:0] pm, output logic fl);
    logic [15:0] egress;
    egress = 16'hFFFF;
    egress[v.inport] = 1'b0;
    if (!v.dmac[40] && (v.lk_resp == R_ACK || v.lk_resp == R_BOTH)) begin
      pm = v.lk_result & egress;
      fl = 1'b0;
    end else begin
      pm = egress;
      fl = 1'b1;
    end
  endfunction

  function automatic vec_t mk(input logic [47:0] dmac, input logic [47:0] smac, input logic [3:0] inport,
                              input resp_t lr, input resp_t kr, input logic [15:0] res, input int dly,
                              input bit noise, input logic [15:0] pm, input logic fl);
    vec_t v;
    v.dmac = dmac; v.smac = smac; v.inport = inport; v.learn_resp = lr; v.lk_resp = kr;
    v.lk_result = res; v.dly = dly; v.noise = noise; v.exp_pm = pm; v.exp_fl = fl;
    return v;
  endfunction

  task automatic runTxn(input vec_t v);
    int          w, lat, age, high_cnt, n_learn, n_lookup, hold;
    bit          done, waiting, stable_ok, hold_ok;
    resp_t       code;
    logic        r_src;
    logic [47:0] r_mac;
    logic [15:0] r_pm, cap_pm;
    logic [9:0]  r_hash;
    logic        cap_fl;

    code = R_NONE; r_src = 1'b0; r_mac = '0; r_pm = '0; r_hash = '0;
    age = 0; high_cnt = 0; stable_ok = 1'b1;
    w = 0;
    while (!bus.hdr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    applyStimulus(v.dmac, v.smac, v.inport, 1'b1);
    checkOutput("hdr_ready_idle", bus.hdr_ready, 1);
    @(negedge clk);
    bus.hdr_valid = 1'b0;

    lat = 1; done = 1'b0; waiting = 1'b0; n_learn = 0; n_lookup = 0;
    while (!done && lat < 1200) begin
      bus.se_ack = 1'b0;
      bus.se_nak = 1'b0;
      if (bus.se_req) begin
        if (!waiting) begin
          waiting = 1'b1; age = 0; high_cnt = 0; stable_ok = 1'b1;
          r_src = bus.se_source; r_mac = bus.se_mac; r_pm = bus.se_portmap; r_hash = bus.se_hash;
          if (r_src) begin
            n_learn++;
            code = v.learn_resp;
            checkOutput("learn_mac", bus.se_mac, v.smac);
            checkOutput("learn_portmap", bus.se_portmap, 16'h1 << v.inport);
            checkOutput("learn_hash", bus.se_hash, hash_ref(v.smac));
          end else begin
            n_lookup++;
            code = v.lk_resp;
            checkOutput("lookup_mac", bus.se_mac, v.dmac);
            checkOutput("lookup_hash", bus.se_hash, hash_ref(v.dmac));
          end
        end else if (bus.se_source !== r_src || bus.se_mac !== r_mac ||
                     bus.se_portmap !== r_pm || bus.se_hash !== r_hash) begin
          stable_ok = 1'b0;
        end
        high_cnt++;
        if (code != R_NONE && age == v.dly) begin
          bus.se_ack    = (code == R_ACK || code == R_BOTH);
          bus.se_nak    = (code == R_NAK || code == R_BOTH);
          bus.se_result = v.lk_result;
        end
        age++;
      end else begin
        if (waiting) begin
          waiting = 1'b0;
          checkOutput("se_req_width", high_cnt, (code == R_NONE) ? 255 : v.dly + 1);
          checkOutput("se_stable", stable_ok, 1);
        end
        if (v.noise) begin
          bus.se_ack    = 1'($urandom_range(0, 1));
          bus.se_nak    = 1'($urandom_range(0, 1));
          bus.se_result = 16'($urandom);
        end
      end
      if (bus.fwd_valid) done = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    bus.se_ack = 1'b0;
    bus.se_nak = 1'b0;

    checkOutput("fwd_seen", done, 1);
    if (done) begin
      checkOutput("fwd_portmap", bus.fwd_portmap, v.exp_pm);
      checkOutput("fwd_flood", bus.fwd_flood, v.exp_fl);
      checkOutput("latency_ge3", lat >= 3, 1);
      checkOutput("learn_reqs", n_learn, !v.smac[40]);
      checkOutput("lookup_reqs", n_lookup, !v.dmac[40]);
      cap_pm = bus.fwd_portmap; cap_fl = bus.fwd_flood; hold_ok = 1'b1;
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        @(negedge clk);
        if (!bus.fwd_valid || bus.fwd_portmap !== cap_pm || bus.fwd_flood !== cap_fl) hold_ok = 1'b0;
      end
      checkOutput("fwd_hold", hold_ok, 1);
      bus.fwd_ready = 1'b1;
      @(negedge clk);
      bus.fwd_ready = 1'b0;
      checkOutput("fwd_release", bus.fwd_valid, 0);
      checkOutput("idle_after_fwd", bus.hdr_ready, 1);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_hdr_ready"}, bus.hdr_ready, 0);
    checkOutput({tag, "_fwd_valid"}, bus.fwd_valid, 0);
    checkOutput({tag, "_fwd_portmap"}, bus.fwd_portmap, 0);
    checkOutput({tag, "_fwd_flood"}, bus.fwd_flood, 0);
    checkOutput({tag, "_se_req"}, bus.se_req, 0);
    checkOutput({tag, "_se_source"}, bus.se_source, 0);
    checkOutput({tag, "_se_mac"}, bus.se_mac, 0);
    checkOutput({tag, "_se_portmap"}, bus.se_portmap, 0);
    checkOutput({tag, "_se_hash"}, bus.se_hash, 0);
    checkOutput({tag, "_aging_req"}, bus.aging_req, 0);
  endtask

  initial begin
    #800_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs[8];
    vec_t        v;
    logic [63:0] r;
    bit          quiet;
    int          n;

    tests = 0; failures = 0;
    rstn = 1'b0;
    applyStimulus('0, '0, '0, 1'b0);
    bus.fwd_ready = 1'b0; bus.se_ack = 1'b0; bus.se_nak = 1'b0;
    bus.se_result = '0; bus.aging_ack = 1'b0;

    vecs[0] = mk(48'h00AABBCCDDEE, 48'h001122334455, 4'd3,  R_ACK,  R_ACK,  16'h0009, 0, 1'b0, 16'h0001, 1'b0);
    vecs[1] = mk(48'h00AABBCCDDEF, 48'h020000000001, 4'd0,  R_NAK,  R_NAK,  16'h0000, 1, 1'b1, 16'hFFFE, 1'b1);
    vecs[2] = mk(48'hFFFFFFFFFFFF, 48'h001122334455, 4'd5,  R_ACK,  R_ACK,  16'h0000, 2, 1'b0, 16'hFFDF, 1'b1);
    vecs[3] = mk(48'h005056000001, 48'h005056000002, 4'd7,  R_ACK,  R_NONE, 16'h0000, 0, 1'b0, 16'hFF7F, 1'b1);
    vecs[4] = mk(48'h00AABBCCDDEE, 48'h0A0B0C0D0E0F, 4'd4,  R_BOTH, R_BOTH, 16'hF0F0, 3, 1'b1, 16'hF0E0, 1'b0);
    vecs[5] = mk(48'h001B21000001, 48'h010000000001, 4'd15, R_ACK,  R_ACK,  16'hFFFF, 1, 1'b0, 16'h7FFF, 1'b0);
    vecs[6] = mk(48'h001B21000002, 48'h001B21000003, 4'd2,  R_NONE, R_ACK,  16'h0006, 0, 1'b1, 16'h0002, 1'b0);
    vecs[7] = mk(48'h01005E000001, 48'h333300000001, 4'd1,  R_ACK,  R_ACK,  16'h0000, 0, 1'b1, 16'hFFFD, 1'b1);

    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rstn = 1'b1;
    #1;
    checkOutput("hdr_ready_release", bus.hdr_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 8; i++) runTxn(vecs[i]);

    for (int i = 0; i < 24; i++) begin
      r = {$urandom, $urandom};
      v.dmac = r[47:0];
      v.dmac[40] = ($urandom_range(0, 3) == 0);
      r = {$urandom, $urandom};
      v.smac = r[47:0];
      v.smac[40] = ($urandom_range(0, 3) == 0);
      v.inport = 4'($urandom_range(0, 15));
      n = $urandom_range(0, 19);
      v.learn_resp = (n < 10) ? R_ACK : (n < 16) ? R_NAK : (n < 18) ? R_BOTH : R_NONE;
      n = $urandom_range(0, 19);
      v.lk_resp = (n < 10) ? R_ACK : (n < 16) ? R_NAK : (n < 18) ? R_BOTH : R_NONE;
      v.lk_result = 16'($urandom);
      v.dly = $urandom_range(0, 5);
      v.noise = 1'($urandom_range(0, 1));
      ref_decision(v, v.exp_pm, v.exp_fl);
      runTxn(v);
    end

    // Reset while a learn request is outstanding: nothing may be replayed afterwards.
    @(negedge clk);
    applyStimulus(48'h00AABBCCDDEE, 48'h001122334455, 4'd6, 1'b1);
    @(negedge clk);
    bus.hdr_valid = 1'b0;
    checkOutput("learn_before_reset", bus.se_req, 1);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    checkResetValues("midreq");
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checkOutput("hdr_ready_rerelease", bus.hdr_ready, 1);
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.se_req || bus.fwd_valid) quiet = 1'b0;
    end
    checkOutput("no_replay", quiet, 1);

`ifdef MAC_AGING_EN
    rstn = 1'b0;
    #1;
    checkOutput("aging_reset", bus.aging_req, 0);
    @(negedge clk);
    rstn = 1'b1;
    n = 0;
    while (!bus.aging_req && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("aging_first_rise", n, 100);
    quiet = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (!bus.aging_req) quiet = 1'b0;
    end
    checkOutput("aging_hold", quiet, 1);
    bus.aging_ack = 1'b1;
    @(negedge clk);
    bus.aging_ack = 1'b0;
    checkOutput("aging_clear", bus.aging_req, 0);
    n = 0;
    while (!bus.aging_req && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("aging_second_rise", n, 100);
`else
    bus.aging_ack = 1'b1;
    repeat (3) @(negedge clk);
    bus.aging_ack = 1'b0;
    @(negedge clk);
    checkOutput("aging_tied_low", bus.aging_req, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
